// File: rtl/interval_pkg.sv
// Shared types and constants for the interval pulse generator.
// With INTERVAL_DITHER_EN defined, the LFSR constants below drive the per-pulse delay dither.
package interval_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned PER_WIDTH_DEF = 16;
    localparam int unsigned DLY_WIDTH_DEF = 16;
    localparam int unsigned NUM_WIDTH_DEF = 8;

    localparam int unsigned LFSR_WIDTH = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions 0,2,3,5 of a right-shifting register
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'h002D;

    // One Fibonacci step: feedback enters at the MSB, register shifts right
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/interval_pulse_gen_if.sv
// Control/config and pulse-output bundle of the interval pulse generator.
// INTERVAL_DITHER_EN adds the dither_sum signal.
interface interval_pulse_gen_if #(
    parameter int unsigned PER_WIDTH = 16,
    parameter int unsigned DLY_WIDTH = 16,
    parameter int unsigned NUM_WIDTH = 8
);
    logic                 start;
    logic                 stop;
    logic [PER_WIDTH-1:0] period;
    logic [DLY_WIDTH-1:0] delay;
    logic [DLY_WIDTH-1:0] width;
    logic [NUM_WIDTH-1:0] num_pulses;
    logic                 sig_a;
    logic                 sig_b;
    logic                 busy;
    logic                 done;
    logic                 cfg_err;
    logic [NUM_WIDTH-1:0] pulse_idx;
`ifdef INTERVAL_DITHER_EN
    logic [NUM_WIDTH:0]   dither_sum;

    modport master (
        output start, stop, period, delay, width, num_pulses,
        input  sig_a, sig_b, busy, done, cfg_err, pulse_idx, dither_sum
    );
    modport slave (
        input  start, stop, period, delay, width, num_pulses,
        output sig_a, sig_b, busy, done, cfg_err, pulse_idx, dither_sum
    );
`else
    modport master (
        output start, stop, period, delay, width, num_pulses,
        input  sig_a, sig_b, busy, done, cfg_err, pulse_idx
    );
    modport slave (
        input  start, stop, period, delay, width, num_pulses,
        output sig_a, sig_b, busy, done, cfg_err, pulse_idx
    );
`endif
endinterface

// File: rtl/interval_lfsr16.sv
// 16-bit Fibonacci LFSR used to dither the per-pulse delay (INTERVAL_DITHER_EN builds only).
module interval_lfsr16
    import interval_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  en,
    output logic [LFSR_WIDTH-1:0] state
);

    // Reload the seed at burst start, otherwise step once per enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LFSR_SEED;
        end else if (load) begin
            state <= LFSR_SEED;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/interval_pulse_gen.sv
// Burst generator of sig_a/sig_b pulse pairs with a programmed sig_a->sig_b delay.
// Optional macro INTERVAL_DITHER_EN: LFSR adds 0/1 cycle to each pulse's delay and reports dither_sum.
module interval_pulse_gen
    import interval_pkg::*;
#(
    parameter int unsigned PER_WIDTH = PER_WIDTH_DEF,
    parameter int unsigned DLY_WIDTH = DLY_WIDTH_DEF,
    parameter int unsigned NUM_WIDTH = NUM_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    interval_pulse_gen_if.slave bus
);

    localparam int unsigned SUM_W = ((DLY_WIDTH > PER_WIDTH) ? DLY_WIDTH : PER_WIDTH) + 1;
`ifdef INTERVAL_DITHER_EN
    localparam int unsigned DITHER_PAD = 1;
`else
    localparam int unsigned DITHER_PAD = 0;
`endif

    state_t               state;
    logic [PER_WIDTH-1:0] ph;
    logic [PER_WIDTH-1:0] per_q;
    logic [DLY_WIDTH-1:0] dly_q;
    logic [DLY_WIDTH-1:0] wid_q;
    logic [NUM_WIDTH-1:0] num_q;
    logic [NUM_WIDTH-1:0] idx_q;
    logic                 sig_a_q;
    logic                 sig_b_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 cfg_err_q;

    logic                 cfg_ok_c;
    logic                 accept_c;
    logic                 wrap_c;
    logic                 last_c;
    logic                 dith_bit_c;
    logic [PER_WIDTH-1:0] ph_next_c;
    logic [SUM_W-1:0]     dly_eff_c;
    logic                 a_next_c;
    logic                 b_next_c;

    // Config check at widened precision so delay+width can never wrap
    always_comb begin
        cfg_ok_c = (bus.delay != '0) && (bus.width != '0) && (bus.num_pulses != '0) &&
                   ((SUM_W'(bus.delay) + SUM_W'(bus.width) + SUM_W'(DITHER_PAD)) < SUM_W'(bus.period));
        accept_c = (state == IDLE) && bus.start && !bus.stop && cfg_ok_c;
    end

    // Next phase and the pulse windows it falls in
    always_comb begin
        wrap_c    = (ph == (per_q - PER_WIDTH'(1)));
        last_c    = (idx_q == (num_q - NUM_WIDTH'(1)));
        ph_next_c = wrap_c ? '0 : (ph + PER_WIDTH'(1));
        dly_eff_c = SUM_W'(dly_q) + SUM_W'(dith_bit_c);
        a_next_c  = SUM_W'(ph_next_c) < SUM_W'(wid_q);
        b_next_c  = (SUM_W'(ph_next_c) >= dly_eff_c) &&
                    (SUM_W'(ph_next_c) < (dly_eff_c + SUM_W'(wid_q)));
    end

    // Control FSM, phase counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ph        <= '0;
            per_q     <= '0;
            dly_q     <= '0;
            wid_q     <= '0;
            num_q     <= '0;
            idx_q     <= '0;
            sig_a_q   <= 1'b0;
            sig_b_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (cfg_ok_c) begin
                            state   <= RUN;
                            per_q   <= bus.period;
                            dly_q   <= bus.delay;
                            wid_q   <= bus.width;
                            num_q   <= bus.num_pulses;
                            ph      <= '0;
                            idx_q   <= '0;
                            sig_a_q <= 1'b1;
                            sig_b_q <= 1'b0;
                            busy_q  <= 1'b1;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state   <= IDLE;
                        ph      <= '0;
                        sig_a_q <= 1'b0;
                        sig_b_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (wrap_c && last_c) begin
                        state   <= DONE;
                        ph      <= '0;
                        sig_a_q <= 1'b0;
                        sig_b_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ph      <= ph_next_c;
                        sig_a_q <= a_next_c;
                        sig_b_q <= b_next_c;
                        if (wrap_c) begin
                            idx_q <= idx_q + NUM_WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef INTERVAL_DITHER_EN
    localparam int unsigned DS_W = NUM_WIDTH + 1;

    logic [LFSR_WIDTH-1:0] lfsr_q;
    logic                  lfsr_en_c;
    logic                  lfsr_unused_c;
    logic [DS_W-1:0]       dsum_q;

    assign lfsr_en_c     = (state == RUN) && wrap_c && !bus.stop;
    assign dith_bit_c    = lfsr_q[0];
    assign lfsr_unused_c = ^lfsr_q[LFSR_WIDTH-1:1];

    interval_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_c),
        .en    (lfsr_en_c),
        .state (lfsr_q)
    );

    // Count dithered pulses: sample the LFSR in the first cycle of each pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dsum_q <= '0;
        end else if (accept_c) begin
            dsum_q <= '0;
        end else if ((state == RUN) && (ph == '0) && !bus.stop) begin
            dsum_q <= dsum_q + DS_W'(lfsr_q[0]);
        end
    end

    assign bus.dither_sum = dsum_q;
`else
    assign dith_bit_c = 1'b0;
`endif

    assign bus.sig_a     = sig_a_q;
    assign bus.sig_b     = sig_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.pulse_idx = idx_q;

endmodule

// File: tb/tb_interval_pulse_gen.sv
// Self-checking bench for interval_pulse_gen (also covers INTERVAL_DITHER_EN when defined).
`timescale 1ns/1ps
module tb_interval_pulse_gen;

    localparam int unsigned PW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned NW = 8;
`ifdef INTERVAL_DITHER_EN
    localparam int DITHER = 1;
`else
    localparam int DITHER = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interval_pulse_gen_if #(.PER_WIDTH(PW), .DLY_WIDTH(DW), .NUM_WIDTH(NW)) bus ();

    interval_pulse_gen #(.PER_WIDTH(PW), .DLY_WIDTH(DW), .NUM_WIDTH(NW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int unsigned p;
        int unsigned d;
        int unsigned w;
        int unsigned n;
        bit          ok;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int unsigned p, input int unsigned d, input int unsigned w, input int unsigned n);
        bus.period     = PW'(p);
        bus.delay      = DW'(d);
        bus.width      = DW'(w);
        bus.num_pulses = NW'(n);
    endtask

    function automatic logic [31:0] outs();
        return {19'd0, bus.cfg_err, bus.sig_a, bus.sig_b, bus.busy, bus.done, bus.pulse_idx};
    endfunction

    // Reference dither: bit0 of the LFSR after k period wraps, LFSR as an integer polynomial
    function automatic int ref_extra(input int k);
        int unsigned s;
        int unsigned fb;
        s = 32'hACE1;
        for (int i = 0; i < k; i++) begin
            fb = ((s >> 0) ^ (s >> 2) ^ (s >> 3) ^ (s >> 5)) & 32'd1;
            s  = (s >> 1) | (fb << 15);
        end
        return (DITHER != 0) ? int'(s & 32'd1) : 0;
    endfunction

    // Full burst against a per-cycle model; optional ignored start and start held through DONE
    task automatic run_burst(input int p, input int d, input int w, input int n,
                             input int inj_t, input bit hold_start, input string tag);
        int   total;
        int   ph;
        int   k;
        int   e;
        int   esum;
        int   ra;
        int   rb;
        int   dist_sum;
        logic a_exp;
        logic b_exp;
        logic pa;
        logic pb;
        int   ex[$];
        total    = p * n;
        esum     = 0;
        dist_sum = 0;
        ra       = -1;
        rb       = -1;
        pa       = 1'b0;
        pb       = 1'b0;
        for (int i = 0; i < n; i++) begin
            ex.push_back(ref_extra(i));
            esum += ex[i];
        end
        set_cfg(p, d, w, n);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int t = 0; t < total; t++) begin
            ph    = t % p;
            k     = t / p;
            e     = ex[k];
            a_exp = (ph < w);
            b_exp = (ph >= d + e) && (ph < d + e + w);
            chk($sformatf("%s_t%0d", tag, t), outs(),
                {19'd0, 1'b0, a_exp, b_exp, 1'b1, 1'b0, NW'(k)});
            if (ph == 0) begin
                ra = -1;
                rb = -1;
            end
            if (bus.sig_a && !pa) ra = t;
            if (bus.sig_b && !pb) rb = t;
            pa = bus.sig_a;
            pb = bus.sig_b;
            if (ph == p - 1) begin
                chk($sformatf("%s_dist_p%0d", tag, k), 32'(rb - ra), 32'(d + e));
                dist_sum += rb - ra;
            end
            if (t == inj_t) begin
                set_cfg(7, 2, 1, 1);
                bus.start = 1'b1;
            end else if (t == inj_t + 1) begin
                set_cfg(p, d, w, n);
                bus.start = 1'b0;
            end
            if (hold_start && t == total - 1) bus.start = 1'b1;
            tick();
        end
        chk({tag, "_done"}, outs(), {19'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, NW'(n - 1)} & 32'hFFFF_FF00
            | (outs() & 32'h0000_00FF));
        chk({tag, "_dist_total"}, 32'(dist_sum), 32'(d * n + esum));
`ifdef INTERVAL_DITHER_EN
        chk({tag, "_dither_sum"}, 32'(bus.dither_sum), 32'(esum));
`endif
        tick();
        if (hold_start) begin
            chk({tag, "_hold_idle"}, 32'({bus.busy, bus.done, bus.sig_a}), 32'b000);
            tick();
            chk({tag, "_hold_accept"}, outs(), {19'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, NW'(0)});
            bus.start = 1'b0;
            bus.stop  = 1'b1;
            tick();
            bus.stop  = 1'b0;
            chk({tag, "_hold_stop"}, 32'({bus.busy, bus.sig_a, bus.sig_b}), 32'b000);
        end else begin
            chk({tag, "_done_1cyc"}, 32'({bus.done, bus.busy}), 32'b00);
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[8];
        int   p;
        int   d;
        int   w;
        int   n;
        bit   seen;

        vecs[0] = '{20, 17, 3, 4, 1'b0};
        vecs[1] = '{20,  5, 0, 4, 1'b0};
        vecs[2] = '{20,  5, 3, 0, 1'b0};
        vecs[3] = '{20,  0, 3, 4, 1'b0};
        vecs[4] = '{20, 16, 3, 1, (DITHER == 0)};
        vecs[5] = '{32'hFFFF, 32'hFFFF, 2, 1, 1'b0};
        vecs[6] = '{3,   1, 1, 1, (DITHER == 0)};
        vecs[7] = '{20,  5, 3, 4, 1'b1};

        bus.start = 1'b0;
        bus.stop  = 1'b0;
        set_cfg(20, 5, 3, 4);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #11;
        chk("reset_state", outs(), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Config validity table
        for (int i = 0; i < 8; i++) begin
            set_cfg(vecs[i].p, vecs[i].d, vecs[i].w, vecs[i].n);
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk($sformatf("cfg%0d_accept", i), 32'({bus.cfg_err, bus.busy, bus.sig_a, bus.sig_b}),
                32'({!vecs[i].ok, vecs[i].ok, vecs[i].ok, 1'b0}));
            if (vecs[i].ok) begin
                bus.stop = 1'b1;
                tick();
                bus.stop = 1'b0;
                chk($sformatf("cfg%0d_stop", i), 32'({bus.busy, bus.sig_a, bus.sig_b, bus.done}), 32'd0);
            end else begin
                tick();
                chk($sformatf("cfg%0d_err_1cyc", i), 32'({bus.cfg_err, bus.busy, bus.sig_a}), 32'd0);
            end
            tick();
        end

        // start together with stop in IDLE: dropped, no error
        set_cfg(20, 5, 3, 4);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        chk("start_stop_idle", 32'({bus.busy, bus.cfg_err, bus.sig_a}), 32'd0);
        tick();

        run_burst(20, 5, 3, 4, -1, 1'b0, "nom");
        run_burst(20, 5, 3, 4, 33, 1'b0, "ign");
        run_burst(20, 5, 3, 4, -1, 1'b1, "hold");

        // Abort at pulse 2, phase 6
        set_cfg(20, 5, 3, 4);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (46) tick();
        chk("abort_pre", outs(), {19'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, NW'(2)});
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("abort_post", 32'({bus.sig_a, bus.sig_b, bus.busy, bus.done}), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.done || bus.busy) seen = 1'b1;
            tick();
        end
        chk("abort_no_done", 32'(seen), 32'd0);
        run_burst(20, 5, 3, 4, -1, 1'b0, "restart");

        // Asynchronous reset at pulse 1, phase 4
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (24) tick();
        chk("rst_pre", 32'({bus.busy, bus.pulse_idx}), 32'({1'b1, NW'(1)}));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", outs(), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        chk("rst_release", outs(), 32'd0);
        tick();

        // Randomized valid configurations
        for (int r = 0; r < 6; r++) begin
            p = int'($urandom_range(4, 40));
            n = int'($urandom_range(1, 4));
            w = int'($urandom_range(1, p - 2 - DITHER));
            d = int'($urandom_range(1, p - 1 - DITHER - w));
            run_burst(p, d, w, n, -1, 1'b0, $sformatf("rnd%0d", r));
        end

`ifdef INTERVAL_DITHER_EN
        run_burst(20, 5, 3, 100, -1, 1'b0, "dith");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
